// File: rtl/jtoutrun_subarb_if.sv
// rtl/jtoutrun_subarb_if.sv - shared sub-bus arbitration signal bundle
//
// Groups the main-CPU request/ack, 68000 bus-arbitration and shared-memory
// signals between the arbiter and its environment.
//   slave  : arbiter side (jtoutrun_subarb)
//   master : environment side (main CPU, sub CPU, memory)
//
// Signals:
//   main_req   main CPU wants the shared sub bus (held until main_ok)
//   main_rnw   main access direction, 1 = read
//   main_ok    one-cycle completion pulse to main
//   sub_bgn    68000 bus grant, active low
//   sub_asn    sub CPU address strobe, active low
//   sub_brn    bus request to the sub CPU, active low
//   sub_bgackn bus-grant acknowledge to the sub CPU, active low
//   sel_main   shared-bus mux select, 1 = main drives the sub bus
//   mem_cs     memory request on behalf of main
//   mem_rnw    registered main_rnw for the current access
//   mem_ok     shared memory completion
interface jtoutrun_subarb_if;
    logic main_req;
    logic main_rnw;
    logic main_ok;
    logic sub_bgn;
    logic sub_asn;
    logic sub_brn;
    logic sub_bgackn;
    logic sel_main;
    logic mem_cs;
    logic mem_rnw;
    logic mem_ok;

    modport slave (
        input  main_req, main_rnw, sub_bgn, sub_asn, mem_ok,
        output main_ok, sub_brn, sub_bgackn, sel_main, mem_cs, mem_rnw
    );

    modport master (
        output main_req, main_rnw, sub_bgn, sub_asn, mem_ok,
        input  main_ok, sub_brn, sub_bgackn, sel_main, mem_cs, mem_rnw
    );
endinterface

// File: rtl/jtoutrun_subarb.sv
// rtl/jtoutrun_subarb.sv - main CPU access arbiter for the shared sub-CPU bus
//
// Lets the main CPU borrow the sub CPU (68000) bus: requests the bus with
// sub_brn, waits for the grant outside any sub bus cycle, takes the bus with
// sub_bgackn/sel_main, issues one memory access and pulses main_ok when the
// memory completes.
//
// Parameters:
//   HOLD  (1..15, default 4) minimum cycles the sub CPU keeps the bus after a
//         main access before the next main request is raised. Only used when
//         JTOUTRUN_SUBFAIR_EN is defined.
//
// Build option:
//   JTOUTRUN_SUBFAIR_EN  defined   : DONE -> HOLD -> IDLE, HOLD counter present
//                        undefined : DONE -> IDLE, no HOLD state or counter
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    jtoutrun_subarb_if.slave (request, arbitration and memory signals)
module jtoutrun_subarb #(
    parameter int HOLD = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    jtoutrun_subarb_if.slave        bus
);

    if (HOLD < 1 || HOLD > 15) begin : g_bad_hold
        $error("jtoutrun_subarb: HOLD must be in 1..15");
    end

`ifdef JTOUTRUN_SUBFAIR_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACC,
        ST_DONE,
        ST_HOLD
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD - 1);
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACC,
        ST_DONE
    } state_t;
`endif

    state_t state_q, state_d;
    logic   brn_q, brn_d;
    logic   bgackn_q, bgackn_d;
    logic   cs_q, cs_d;
    logic   rnw_q, rnw_d;
    logic   ok_q, ok_d;
`ifdef JTOUTRUN_SUBFAIR_EN
    logic [3:0] cnt_q, cnt_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            brn_q    <= 1'b1;
            bgackn_q <= 1'b1;
            cs_q     <= 1'b0;
            rnw_q    <= 1'b1;
            ok_q     <= 1'b0;
`ifdef JTOUTRUN_SUBFAIR_EN
            cnt_q    <= 4'd0;
`endif
        end else begin
            state_q  <= state_d;
            brn_q    <= brn_d;
            bgackn_q <= bgackn_d;
            cs_q     <= cs_d;
            rnw_q    <= rnw_d;
            ok_q     <= ok_d;
`ifdef JTOUTRUN_SUBFAIR_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        brn_d    = brn_q;
        bgackn_d = bgackn_q;
        cs_d     = cs_q;
        rnw_d    = rnw_q;
        ok_d     = 1'b0;
`ifdef JTOUTRUN_SUBFAIR_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.main_req) begin
                    state_d = ST_REQ;
                    brn_d   = 1'b0;
                end
            end
            ST_REQ: begin
                if (!bus.main_req) begin
                    state_d = ST_IDLE;
                    brn_d   = 1'b1;
                end else if (!bus.sub_bgn && bus.sub_asn) begin
                    // Take the bus only between sub CPU bus cycles (AS high).
                    state_d  = ST_ACC;
                    brn_d    = 1'b1;
                    bgackn_d = 1'b0;
                    cs_d     = 1'b1;
                    rnw_d    = bus.main_rnw;
                end
            end
            ST_ACC: begin
                // main_req is deliberately ignored: a started access completes.
                if (bus.mem_ok) begin
                    state_d = ST_DONE;
                    cs_d    = 1'b0;
                    ok_d    = 1'b1;
`ifdef JTOUTRUN_SUBFAIR_EN
                    // The count starts with DONE so that the bus-released
                    // window before the next request is HOLD cycles long.
                    cnt_d   = HOLD_LOAD;
`endif
                end
            end
            ST_DONE: begin
                bgackn_d = 1'b1;
`ifdef JTOUTRUN_SUBFAIR_EN
                state_d  = ST_HOLD;
                cnt_d    = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
`else
                state_d  = ST_IDLE;
`endif
            end
`ifdef JTOUTRUN_SUBFAIR_EN
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.sub_brn    = brn_q;
    assign bus.sub_bgackn = bgackn_q;
    // Derived from the acknowledge so the mux select can never disagree with it.
    assign bus.sel_main   = ~bgackn_q;
    assign bus.mem_cs     = cs_q;
    assign bus.mem_rnw    = rnw_q;
    assign bus.main_ok    = ok_q;

endmodule

// File: tb/tb_jtoutrun_subarb.sv
// tb/tb_jtoutrun_subarb.sv - self-checking bench for jtoutrun_subarb
module tb_jtoutrun_subarb;
    localparam int HOLD_P = 4;
`ifdef JTOUTRUN_SUBFAIR_EN
    localparam int EXP_GAP = (HOLD_P < 2) ? 2 : HOLD_P;
`else
    localparam int EXP_GAP = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    jtoutrun_subarb_if bus();

    jtoutrun_subarb #(.HOLD(HOLD_P)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    int   ok_count    = 0;
    logic exp_q[$];
    bit   prev_ok     = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_brn"},    bus.sub_brn,    1);
        check({pfx, "_bgackn"}, bus.sub_bgackn, 1);
        check({pfx, "_sel"},    bus.sel_main,   0);
        check({pfx, "_cs"},     bus.mem_cs,     0);
        check({pfx, "_rnw"},    bus.mem_rnw,    1);
        check({pfx, "_ok"},     bus.main_ok,    0);
    endtask

    task automatic wait_ok(input string tag, input int max_cyc, output int cyc);
        cyc = 0;
        while (cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (bus.main_ok === 1'b1) break;
        end
        check(tag, bus.main_ok, 1);
    endtask

    task automatic idle_inputs();
        bus.main_req = 1'b0;
        bus.main_rnw = 1'b1;
        bus.sub_bgn  = 1'b1;
        bus.sub_asn  = 1'b1;
        bus.mem_ok   = 1'b0;
    endtask

    // Scoreboard consumer: every main_ok must match a queued request.
    always @(negedge clk) begin
        check("sel_vs_bgackn", bus.sel_main, !bus.sub_bgackn);
        if (bus.main_ok === 1'b1) begin
            ok_count++;
            check("ok_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("mem_rnw", bus.mem_rnw, exp_q.pop_front());
        end
        check("ok_single", prev_ok && (bus.main_ok === 1'b1), 0);
        prev_ok = (bus.main_ok === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int gap;
        idle_inputs();
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Grant one cycle after the request, mem_ok two cycles after ACC.
        bus.main_req = 1'b1; bus.main_rnw = 1'b1; exp_q.push_back(1'b1);
        @(negedge clk);
        check("t1_brn_low", bus.sub_brn, 0);
        check("t1_bgackn_wait", bus.sub_bgackn, 1);
        bus.sub_bgn = 1'b0;
        @(negedge clk);
        check("t1_brn_high", bus.sub_brn, 1);
        check("t1_bgackn", bus.sub_bgackn, 0);
        check("t1_cs", bus.mem_cs, 1);
        check("t1_rnw", bus.mem_rnw, 1);
        @(negedge clk);
        check("t1_cs_hold", bus.mem_cs, 1);
        check("t1_ok_early", bus.main_ok, 0);
        bus.mem_ok = 1'b1;
        @(negedge clk);
        check("t1_ok", bus.main_ok, 1);
        check("t1_cs_drop", bus.mem_cs, 0);
        check("t1_bgackn_done", bus.sub_bgackn, 0);
        idle_inputs();
        @(negedge clk);
        check("t1_ok_clear", bus.main_ok, 0);
        check("t1_release", bus.sub_bgackn, 1);
        repeat (6) @(negedge clk);

        // Minimum latency: grant and mem_ok already present (mem_ok in IDLE/REQ ignored).
        bus.sub_bgn = 1'b0; bus.mem_ok = 1'b1;
        bus.main_req = 1'b1; bus.main_rnw = 1'b0; exp_q.push_back(1'b0);
        wait_ok("t2_ok", 10, cyc);
        check("t2_latency", cyc, 3);
        idle_inputs();
        repeat (6) @(negedge clk);

        // Sub CPU mid-cycle (AS low) for 5 cycles blocks ACC entry.
        bus.sub_bgn = 1'b0; bus.sub_asn = 1'b0;
        bus.main_req = 1'b1; bus.main_rnw = 1'b1; exp_q.push_back(1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_cs_blocked", bus.mem_cs, 0);
            check("t3_bgackn_blocked", bus.sub_bgackn, 1);
        end
        bus.sub_asn = 1'b1;
        @(negedge clk);
        check("t3_cs", bus.mem_cs, 1);
        check("t3_bgackn", bus.sub_bgackn, 0);
        bus.mem_ok = 1'b1;
        wait_ok("t3_ok", 10, cyc);
        check("t3_latency", cyc, 1);
        idle_inputs();
        repeat (6) @(negedge clk);

        // mem_ok strobed in IDLE, then request withdrawn before the grant.
        bus.mem_ok = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("t4_idle_cs", bus.mem_cs, 0);
        end
        bus.main_req = 1'b1;
        @(negedge clk);
        check("t4_brn_low", bus.sub_brn, 0);
        bus.main_req = 1'b0;
        @(negedge clk);
        check("t4_brn_release", bus.sub_brn, 1);
        repeat (3) begin
            @(negedge clk);
            check("t4_cs", bus.mem_cs, 0);
            check("t4_ok", bus.main_ok, 0);
        end
        idle_inputs();
        repeat (2) @(negedge clk);

        // Back-to-back requests: measure the released-bus gap.
        bus.sub_bgn = 1'b0; bus.mem_ok = 1'b1;
        bus.main_req = 1'b1; bus.main_rnw = 1'b1; exp_q.push_back(1'b1);
        wait_ok("t5_ok1", 10, cyc);
        bus.main_rnw = 1'b0; exp_q.push_back(1'b0);
        gap = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.sub_brn === 1'b0) break;
            if (bus.sub_brn === 1'b1 && bus.sub_bgackn === 1'b1) gap++;
        end
        check("t5_brn_again", bus.sub_brn, 0);
        check("t5_gap", gap, EXP_GAP);
        wait_ok("t5_ok2", 10, cyc);
        idle_inputs();
        repeat (6) @(negedge clk);

        // Reset in the middle of an access.
        bus.sub_bgn = 1'b0;
        bus.main_req = 1'b1; bus.main_rnw = 1'b0; exp_q.push_back(1'b0);
        @(negedge clk);
        @(negedge clk);
        check("t6_cs", bus.mem_cs, 1);
        check("t6_rnw", bus.mem_rnw, 0);
        #2 rst_n = 1'b0;
        #1 check_reset("t6_rst");
        exp_q.delete();
        bus.main_req = 1'b0;
        bus.mem_ok = 1'b1;
        @(negedge clk);
        check("t6_ok_in_reset", bus.main_ok, 0);
        rst_n = 1'b1;
        bus.main_req = 1'b1; bus.main_rnw = 1'b1; exp_q.push_back(1'b1);
        wait_ok("t6_ok", 10, cyc);
        check("t6_latency", cyc, 3);
        idle_inputs();
        repeat (6) @(negedge clk);

        check("sb_empty", exp_q.size(), 0);
        check("ok_count", ok_count, 6);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/jtoutrun_subarb.md
JTOUTRUN_SUBARB -- requirements
Module: jtoutrun_subarb

Interface
REQ-001 Parameter HOLD, default 4, the minimum number of clk cycles the sub CPU keeps the bus after a main access before the next grant; legal range 1..15.
REQ-002 clk  input  1  system clock; all logic on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 main_req  input  1  main CPU wants the shared sub bus; held high until main_ok is seen.
REQ-005 main_rnw  input  1  main access direction; sampled on REQ->ACC.
REQ-006 sub_bgn  input  1  68000 bus grant from the sub CPU, active low.
REQ-007 sub_asn  input  1  sub CPU address strobe, active low.
REQ-008 mem_ok  input  1  shared memory (SDRAM/RAM) completion for the current access.
REQ-009 sub_brn  output  1  bus request to the sub CPU, active low.
REQ-010 sub_bgackn  output  1  bus-grant acknowledge to the sub CPU, active low.
REQ-011 sel_main  output  1  shared-bus mux select: 1 = main address/data/dsn/rnw drive the sub bus.
REQ-012 mem_cs  output  1  memory request on behalf of main.
REQ-013 mem_rnw  output  1  registered copy of main_rnw for the access.
REQ-014 main_ok  output  1  one-cycle completion pulse to main.

Function
REQ-015 States: IDLE, REQ, ACC, DONE, HOLD; encoding is free.
REQ-016 IDLE: main_req=1 -> REQ; sub_brn goes low on the same edge.
REQ-017 REQ: sub_bgn=0 and sub_asn=1 -> ACC; sub_bgackn=0, sel_main=1, mem_cs=1 and mem_rnw<=main_rnw all on that edge; sub_brn returns high on that edge.
REQ-018 REQ: main_req drops before the grant -> IDLE; sub_brn high on the next edge; no memory request issued.
REQ-019 ACC: mem_cs stays high until mem_ok=1; on that edge -> DONE, mem_cs=0, main_ok=1 for exactly one cycle.
REQ-020 ACC ignores main_req changes; an access, once started, always completes.
REQ-021 mem_ok outside ACC is ignored; main_ok never pulses outside DONE entry.
REQ-022 DONE: the cycle after main_ok, sub_bgackn=1 and sel_main=0, then -> HOLD.
REQ-023 HOLD: 4-bit counter loads HOLD-1 and counts down; at 0 -> IDLE. A main_req present then is served from IDLE normally.
REQ-024 sel_main=1 exactly while sub_bgackn=0; the two never disagree.
REQ-025 Minimum latency, main_req rising to main_ok: 3 cycles (grant and mem_ok each already present).
REQ-026 Sub CPU never loses the bus mid-cycle: ACC is never entered while sub_asn=0.

Reset
REQ-027 rst_n low forces IDLE asynchronously: sub_brn=1, sub_bgackn=1, sel_main=0, mem_cs=0, mem_rnw=1, main_ok=0, HOLD counter=0.
REQ-028 Reset during ACC abandons the access with no main_ok pulse; after release the block starts from IDLE.

Configuration
REQ-029 Macro JTOUTRUN_SUBFAIR_EN: when defined, HOLD behaves as in REQ-023.
REQ-030 When JTOUTRUN_SUBFAIR_EN is not defined, DONE goes straight to IDLE, the HOLD state and counter are absent, and the HOLD parameter is ignored.

Verification
REQ-031 main_req=1 with sub_bgn low 1 cycle later and mem_ok 2 cycles after ACC entry -> sub_brn low 1 cycle, then sel_main/sub_bgackn low until DONE; main_ok pulses once.
REQ-032 sub_asn=0 for 5 cycles while sub_bgn=0 -> stays in REQ with mem_cs=0, then enters ACC on the first cycle with sub_asn=1.
REQ-033 main_req dropped in REQ before the grant -> sub_brn high next cycle; mem_cs and main_ok never assert.
REQ-034 Back-to-back main_req with JTOUTRUN_SUBFAIR_EN and HOLD=4 -> 4 cycles with sub_brn=1 and sub_bgackn=1 between accesses; without the macro -> the next sub_brn falls the cycle after DONE.
REQ-035 rst_n pulsed low mid-ACC -> all outputs at reset values immediately, no main_ok; a fresh main_req after release completes normally.
REQ-036 mem_ok strobed in IDLE and in REQ -> no main_ok; the assertion that sel_main equals ~sub_bgackn holds on every cycle.
